// File: rtl/wshb_mire_writer.sv
// Wishbone classic-cycle master that paints a grid test pattern (mire) into the SDRAM framebuffer,
// one 32-bit pixel per write, releasing the bus every BURST_LEN writes so the VGA reader can be granted.
module wshb_mire_writer #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          BURST_LEN = 64,
    parameter int          GRID      = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    input  logic        ack,
    input  logic        err,
    output logic        frame_done,
    output logic        err_seen
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    // GRID is a power of two, so "coordinate mod GRID == 0" is a mask test on the low bits
    localparam logic [XW-1:0] X_MASK = XW'(GRID - 1);
    localparam logic [YW-1:0] Y_MASK = YW'(GRID - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   adr_q, adr_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          frame_done_q, frame_done_d;
    logic          err_seen_q, err_seen_d;
    logic          last_px_s;
    logic          grid_hit_s;

    assign last_px_s  = (x_q == X_LAST) && (y_q == Y_LAST);
    assign grid_hit_s = ((x_q & X_MASK) == {XW{1'b0}}) || ((y_q & Y_MASK) == {YW{1'b0}});

    // Next-state logic: pixel walk, burst accounting and bus tenure control
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        adr_d        = adr_q;
        burst_d      = burst_q;
        frame_done_d = 1'b0;
        err_seen_d   = err_seen_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                // err wins over a simultaneous ack; the pixel is retried on the next tenure
                if (err) begin
                    err_seen_d = 1'b1;
                    state_d    = S_PAUSE;
                    burst_d    = {BW{1'b0}};
                end else if (ack) begin
                    if (x_q == X_LAST) begin
                        x_d = {XW{1'b0}};
                        if (y_q == Y_LAST) begin
                            y_d          = {YW{1'b0}};
                            adr_d        = BASE_ADDR;
                            frame_done_d = 1'b1;
                        end else begin
                            y_d   = y_q + Y_ONE;
                            adr_d = adr_q + 32'd4;
                        end
                    end else begin
                        x_d   = x_q + X_ONE;
                        adr_d = adr_q + 32'd4;
                    end
                    if ((burst_q == B_LAST) || last_px_s || !enable) begin
                        state_d = S_PAUSE;
                        burst_d = {BW{1'b0}};
                    end else begin
                        state_d = S_WRITE;
                        burst_d = burst_q + B_ONE;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_PAUSE: begin
                if (enable) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                burst_d = {BW{1'b0}};
            end
        endcase
    end

    // State registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= {XW{1'b0}};
            y_q          <= {YW{1'b0}};
            adr_q        <= BASE_ADDR;
            burst_q      <= {BW{1'b0}};
            frame_done_q <= 1'b0;
            err_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            adr_q        <= adr_d;
            burst_q      <= burst_d;
            frame_done_q <= frame_done_d;
            err_seen_q   <= err_seen_d;
        end
    end

    assign cyc        = (state_q == S_WRITE);
    assign stb        = (state_q == S_WRITE);
    assign we         = 1'b1;
    assign sel        = 4'hF;
    assign cti        = 3'b000;
    assign bte        = 2'b00;
    assign adr        = adr_q;
    assign dat_ms     = grid_hit_s ? 32'h00FF_FFFF : 32'h0000_0000;
    assign frame_done = frame_done_q;
    assign err_seen   = err_seen_q;

endmodule

// File: tb/tb_wshb_mire_writer.sv
// Directed bench for wshb_mire_writer on an 8x4 frame with 4-write bursts and a 4-pixel grid.
module tb_wshb_mire_writer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] adr, dat_ms;
    logic        ack, err;
    logic        frame_done, err_seen;

    int n_checks = 0;
    int n_fail   = 0;
    int bc       = 0;
    int fd_count = 0;

    wshb_mire_writer #(
        .HDISP(8), .VDISP(4), .BASE_ADDR(32'h100), .BURST_LEN(4), .GRID(4)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable),
        .cyc(cyc), .stb(stb), .we(we), .sel(sel), .cti(cti), .bte(bte),
        .adr(adr), .dat_ms(dat_ms), .ack(ack), .err(err),
        .frame_done(frame_done), .err_seen(err_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_dat(input int p);
        int x, y;
        x = p % 8;
        y = p / 8;
        return ((x % 4 == 0) || (y == 0)) ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave side of one transfer: wait for stb, check address/data, hold dly cycles, then ack (or err+ack)
    task automatic xfer(input int p, input int dly, input bit use_err,
                        output logic cyc_after, output logic fd);
        int t;
        logic [31:0] ea;
        ea = 32'h100 + 32'(4 * p);
        t = 0;
        while (!stb && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("stb_wait", {31'd0, stb}, 32'd1);
        check("adr", adr, ea);
        check("dat", dat_ms, exp_dat(p));
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("hold_cyc_stb", {30'd0, cyc, stb}, 32'd3);
            check("hold_adr", adr, ea);
            check("hold_dat", dat_ms, exp_dat(p));
        end
        ack = 1'b1;
        if (use_err) err = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        err = 1'b0;
        cyc_after = cyc;
        fd = frame_done;
    endtask

    task automatic pix(input int p, input int dly, input bit use_err);
        logic ca, fd;
        bit pause_exp;
        pause_exp = use_err || (bc == 3) || (p == 31) || !enable;
        xfer(p, dly, use_err, ca, fd);
        check("cyc_after_ack", {31'd0, ca}, {31'd0, !pause_exp});
        check("frame_done", {31'd0, fd}, {31'd0, (!use_err && p == 31)});
        if (fd) fd_count++;
        if (use_err) check("err_seen_set", {31'd0, err_seen}, 32'd1);
        bc = pause_exp ? 0 : bc + 1;
        if (pause_exp && enable) begin
            @(negedge clk);
            check("pause_one_cycle", {31'd0, cyc}, 32'd1);
            check("frame_done_width", {31'd0, frame_done}, 32'd0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        ack    = 1'b0;
        err    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cyc", {31'd0, cyc}, 32'd0);
        check("rst_stb", {31'd0, stb}, 32'd0);
        check("rst_adr", adr, 32'h100);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_err_seen", {31'd0, err_seen}, 32'd0);
        check("const_bus", {20'd0, we, sel, cti, bte}, {20'd0, 1'b1, 4'hF, 3'b000, 2'b00});

        // Frame 1: free-running with burst releases every 4th ack
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("first_stb_latency", {31'd0, stb}, 32'd1);
        fd_count = 0;
        for (int p = 0; p < 32; p++) pix(p, 0, 1'b0);
        check("frame1_done_count", 32'(fd_count), 32'd1);
        check("frame1_no_err", {31'd0, err_seen}, 32'd0);

        // Frame 2: enable drop during 2nd write, then error on pixel 5
        fd_count = 0;
        pix(0, 0, 1'b0);
        enable = 1'b0;
        pix(1, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stopped_stb", {30'd0, cyc, stb}, 32'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("resume_stb", {31'd0, stb}, 32'd1);
        check("resume_adr", adr, 32'h108);
        for (int p = 2; p < 5; p++) pix(p, 0, 1'b0);
        pix(5, 0, 1'b1);
        for (int p = 5; p < 32; p++) pix(p, 0, 1'b0);
        check("frame2_done_count", 32'(fd_count), 32'd1);
        check("err_sticky", {31'd0, err_seen}, 32'd1);

        // Frame 3: slow slave, then spurious ack while idle
        pix(0, 3, 1'b0);
        enable = 1'b0;
        pix(1, 3, 1'b0);
        repeat (2) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        check("idle_ack_adr", adr, 32'h108);
        check("idle_ack_cyc", {30'd0, cyc, stb}, 32'd0);

        // Asynchronous reset in the middle of pixel 10
        enable = 1'b1;
        for (int p = 2; p < 10; p++) pix(p, 0, 1'b0);
        check("pix10_stb", {31'd0, stb}, 32'd1);
        check("pix10_adr", adr, 32'h128);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check("async_rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
        check("async_rst_adr", adr, 32'h100);
        check("async_rst_err_seen", {31'd0, err_seen}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'd0, cyc}, 32'd0);
        enable = 1'b1;
        bc = 0;
        pix(0, 0, 1'b0);
        pix(1, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
